// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the memory responder
package mem_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/word_ram.sv
// word_ram: DEPTH x WORD_W single-port array, synchronous write, registered read
module word_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     Clk,
    input  logic                     we,
    input  logic [idx_w(DEPTH)-1:0]  addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    // Write on we; read data appears one cycle after the address
    always_ff @(posedge Clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: one-at-a-time word request/response responder over an internal array
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    localparam int AW = idx_w(DEPTH);

    state_t            state;
    logic [3:0]        cnt;
    logic [AW-1:0]     idx_q;
    logic              rd_q;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] ram_q;
    logic [AW-1:0]     ram_addr;
    logic              aligned;
    logic              unused_addr;

    assign aligned     = req_addr[1:0] == 2'b00;
    assign ram_addr    = state == IDLE ? req_addr[AW+1:2] : idx_q;
    assign req_ready   = state == IDLE;
    assign busy        = state != IDLE;
    assign resp_rdata  = rd_q ? ram_q : rdata_q;
    assign unused_addr = ^req_addr[31:AW+2];

    // The array is written at the acceptance edge, so a later read always sees it;
    // the read port follows the live address in IDLE so data is ready one cycle later
    word_ram #(.DEPTH(DEPTH)) u_ram (
        .Clk   (Clk),
        .we    (state == IDLE && req_valid && req_write && aligned),
        .addr  (ram_addr),
        .wdata (req_wdata),
        .rdata (ram_q)
    );

    // Request FSM with latency counter and registered response flags
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            rd_q       <= 1'b0;
            rdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_q       <= 1'b0;
            if (rd_q) rdata_q <= ram_q;
            case (state)
                IDLE: if (req_valid) begin
                    idx_q <= req_addr[AW+1:2];
                    if (req_write || !aligned) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= !aligned;
                    end else if (READ_LATENCY <= 1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        rd_q       <= 1'b1;
                    end else begin
                        state <= RD_WAIT;
                        cnt   <= 4'(READ_LATENCY - 1);
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        rd_q       <= 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a transaction model
module tb_mem_responder;
    localparam int L = 3;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req_valid, req_write, req_ready, resp_valid, resp_err, busy;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        r1_valid, r1_write, r1_ready, r1_resp_valid, r1_err, r1_busy;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;

    int n_chk = 0;
    int n_fail = 0;

    mem_responder #(.DEPTH(256), .READ_LATENCY(L)) dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    mem_responder #(.DEPTH(256), .READ_LATENCY(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .req_valid(r1_valid), .req_write(r1_write),
        .req_addr(r1_addr), .req_wdata(r1_wdata), .req_ready(r1_ready),
        .resp_valid(r1_resp_valid), .resp_rdata(r1_rdata), .resp_err(r1_err), .busy(r1_busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Transaction-level model: one outstanding request with a due cycle
    logic [31:0] mem [256];
    logic        pend = 1'b0, p_err, p_rd, rst_hit = 1'b0;
    logic [31:0] p_data, hold = '0;
    int          cyc = 0, due = 0;

    always @(negedge Reset) rst_hit = 1'b1;

    always @(negedge Clk) begin
        logic        e_rdy, e_v, e_e, al;
        logic [31:0] e_d;
        logic [7:0]  idx;
        if (!Reset || rst_hit) begin
            pend    = 1'b0;
            hold    = '0;
            rst_hit = 1'b0;
        end
        e_rdy = !pend;
        e_v   = pend && cyc == due;
        e_e   = e_v && p_err;
        e_d   = (e_v && p_rd) ? p_data : hold;
        chk("m_ready", {31'b0, req_ready}, {31'b0, e_rdy});
        chk("m_busy", {31'b0, busy}, {31'b0, !e_rdy});
        chk("m_resp_valid", {31'b0, resp_valid}, {31'b0, e_v});
        chk("m_resp_err", {31'b0, resp_err}, {31'b0, e_e});
        chk("m_resp_rdata", resp_rdata, e_d);
        if (e_v) begin
            if (p_rd) hold = p_data;
            pend = 1'b0;
        end
        if (Reset && e_rdy && req_valid) begin
            al     = req_addr[1:0] == 2'b00;
            idx    = req_addr[9:2];
            pend   = 1'b1;
            p_err  = !al;
            p_rd   = al && !req_write;
            due    = cyc + ((req_write || !al) ? 1 : L);
            if (al && req_write) mem[idx] = req_wdata;
            if (p_rd) p_data = mem[idx];
        end
        cyc++;
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic err, output logic [31:0] rd,
                        output logic rdy_seen);
        int n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(negedge Clk);
        while (!req_ready && n < 40) begin
            @(negedge Clk);
            n++;
        end
        tick;
        req_valid = 1'b0; req_write = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        lat = 1; rdy_seen = 1'b0;
        @(negedge Clk);
        while (!resp_valid && lat < 40) begin
            rdy_seen |= req_ready;
            @(negedge Clk);
            lat++;
        end
        rdy_seen |= req_ready;
        err = resp_err;
        rd  = resp_rdata;
        if (!resp_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: no resp_valid within %0d cycles, expected one", lat);
        end
        tick;
    endtask

    initial begin
        int          lat, cnt;
        logic        err, rs;
        logic [31:0] rd, a;
        Reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        r1_valid = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
        repeat (2) tick;
        @(negedge Clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        tick;
        Reset = 1'b1;
        repeat (10) tick;
        @(negedge Clk);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
        chk("idle_rdata", resp_rdata, 32'd0);
        tick;

        send(1'b1, 32'h10, 32'hDEADBEEF, lat, err, rd, rs);
        chk("wr_lat", lat, 32'd1);
        chk("wr_err", {31'b0, err}, 32'd0);
        send(1'b0, 32'h10, 32'h0, lat, err, rd, rs);
        chk("rd_lat", lat, 32'd3);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_ready_low", {31'b0, rs}, 32'd0);

        send(1'b1, 32'h04, 32'h12345678, lat, err, rd, rs);
        send(1'b0, 32'h404, 32'h0, lat, err, rd, rs);
        chk("wrap_data", rd, 32'h12345678);

        send(1'b1, 32'h08, 32'hCAFEF00D, lat, err, rd, rs);
        send(1'b0, 32'h0A, 32'h0, lat, err, rd, rs);
        chk("mis_lat", lat, 32'd1);
        chk("mis_err", {31'b0, err}, 32'd1);
        chk("mis_rdata_held", rd, 32'h12345678);
        send(1'b1, 32'h09, 32'h00000BAD, lat, err, rd, rs);
        chk("mis_wr_err", {31'b0, err}, 32'd1);
        send(1'b0, 32'h08, 32'h0, lat, err, rd, rs);
        chk("mis_unmod", rd, 32'hCAFEF00D);
        chk("mis_unmod_err", {31'b0, err}, 32'd0);

        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        tick;
        req_valid = 1'b0;
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge Clk);
            cnt += int'(resp_valid);
        end
        chk("abort_no_resp", cnt, 32'd0);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        tick;

        for (int i = 0; i < 16; i++) send(1'b1, i * 4, $urandom, lat, err, rd, rs);
        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            a[9:2] = 8'($urandom_range(0, 15));
            a[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            req_valid = $urandom_range(0, 9) < 6;
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = a;
            req_wdata = $urandom;
            tick;
        end
        req_valid = 1'b0;
        repeat (10) tick;

        r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 32'h0; r1_wdata = 32'h11111111;
        tick;
        r1_addr = 32'h4; r1_wdata = 32'h22222222;
        tick;
        tick;
        r1_write = 1'b0; r1_addr = 32'h0;
        tick;
        @(negedge Clk);
        chk("l1_ready_T", {31'b0, r1_ready}, 32'd1);
        tick;
        r1_addr = 32'h4;
        @(negedge Clk);
        chk("l1_v1", {31'b0, r1_resp_valid}, 32'd1);
        chk("l1_d1", r1_rdata, 32'h11111111);
        chk("l1_ready_T1", {31'b0, r1_ready}, 32'd0);
        tick;
        @(negedge Clk);
        chk("l1_gap", {31'b0, r1_resp_valid}, 32'd0);
        tick;
        r1_valid = 1'b0;
        @(negedge Clk);
        chk("l1_v2", {31'b0, r1_resp_valid}, 32'd1);
        chk("l1_d2", r1_rdata, 32'h22222222);
        chk("l1_err2", {31'b0, r1_err}, 32'd0);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's control unit.
- Accepts one word read or write request at a time from the datapath's memory port.
- Serves reads from an internal word array after a fixed, parameterised latency; writes complete with a one-cycle acknowledge.
- Replaces the hard-wired memory-delay assumption with an explicit request/response handshake, so the control FSM can wait on resp_valid instead of counting states.

Parameters:
- DEPTH, 256, number of 32-bit words in the array; must be a power of two.
- READ_LATENCY, 3, cycles from request acceptance to read response; legal range 1..15.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = write, 0 = read; sampled with req_valid.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse: the response for the outstanding request.
- resp_rdata  out  32  read data; valid with resp_valid, held until the next response.
- resp_err  out  1  qualifies resp_valid: request was misaligned.
- busy  out  1  a request is outstanding (state != IDLE).

Behaviour:
- Reset (Reset=0, asynchronous):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; busy = 0; latency counter = 0.
  - Array contents are not cleared.
- Acceptance:
  - A request is accepted in cycle T when req_valid=1 and req_ready=1.
  - req_ready=1 only in IDLE, so at most one request is outstanding.
  - Address, write flag and write data are captured at acceptance.
  - The requester may drop or change the req_* inputs after acceptance.
- Word index is req_addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Misaligned request (req_addr[1:0] != 0):
  - No array access occurs; the array is never modified.
  - resp_valid=1 and resp_err=1 at T+1.
  - resp_rdata keeps its previous value.
- Aligned write:
  - Array word is updated at the edge ending cycle T.
  - resp_valid=1, resp_err=0 at T+1.
  - resp_rdata is unchanged.
- Aligned read:
  - resp_valid=1, resp_err=0, resp_rdata = word at T+READ_LATENCY.
  - Data reflects every write accepted before T (read-after-write coherent).
- FSM states:
  - IDLE: on an accepted read → RD_WAIT, counter loaded with READ_LATENCY-1. On an accepted write or misaligned request → RESP.
  - RD_WAIT: counter decrements each cycle. When it reaches 0, the array data is registered and the FSM goes to RESP. With READ_LATENCY=1, RD_WAIT is skipped and a read goes straight to RESP.
  - RESP: drives resp_valid=1 for exactly one cycle, then → IDLE.
- Throughput:
  - Next acceptance is possible at the cycle after RESP.
  - Read to read: READ_LATENCY+1 cycles.
  - Write to write: 2 cycles.
- resp_valid and resp_err are registered outputs. resp_err is 0 whenever resp_valid is 0.
- Reset asserted mid-operation: the outstanding request is aborted and no response is issued. A write already committed at its acceptance edge remains in the array.
- req_valid held high while req_ready=0 has no effect; the request is taken once the FSM returns to IDLE.
- Unknown or illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package mem_pkg:
  - state enum: IDLE, RD_WAIT, RESP.
  - WORD_W = 32.
  - Function for index width: clog2 of DEPTH.
- One sub-module, word_ram:
  - DEPTH x 32 single-port array.
  - Synchronous write; registered read with one cycle of read latency.
  - No reset on contents.
  - The FSM accounts for this cycle when loading the latency counter.
- mem_responder holds the FSM, latency counter, request capture registers and response registers.

Test Plan:
- Reset then idle → req_ready=1, resp_valid=0, resp_rdata=0, busy=0; release Reset with no request → outputs unchanged for 10 cycles.
- Write addr 0x10 data 0xDEADBEEF accepted at T → resp_valid=1, resp_err=0 at T+1 only; read 0x10 accepted at T+2 → resp_rdata=0xDEADBEEF at T+5 (READ_LATENCY=3); req_ready=0 from T+3 through T+5.
- Write addr 0x04 data 0x12345678, then read addr 0x404 with DEPTH=256 → returns 0x12345678 (index wrap).
- Read addr 0x0A → resp_valid=1, resp_err=1 at T+1, resp_rdata unchanged; a later read of 0x08 returns the prior contents, unmodified.
- Read accepted at T, Reset pulsed low at T+1 → no resp_valid in cycles T+1..T+6; req_ready=1 after release.
- READ_LATENCY=1 build: back-to-back reads of 0x00 and 0x04 with req_valid held high → responses at T+1 and T+3, with correct data each.
